// File: rtl/retire_chk_pkg.sv
// -----------------------------------------------------------------------------
// retire_chk_pkg
//   Shared types for the retire checker: FSM state encoding, the check-entry
//   record and a small state-classification helper.
//
//   The check-entry fields are sized to fixed maxima (CHK_RD_W / CHK_VAL_W)
//   because a package type cannot depend on a module parameter. The module
//   zero-extends its XLEN/IDXW-wide values into these fields, so it supports
//   register indices up to CHK_RD_W bits and datapaths up to CHK_VAL_W bits.
// -----------------------------------------------------------------------------
package retire_chk_pkg;

    localparam int CHK_RD_W  = 8;
    localparam int CHK_VAL_W = 128;

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        DRAIN = 3'd1,
        DUMP  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic                 enable;
        logic [CHK_RD_W-1:0]  rd;
        logic [CHK_VAL_W-1:0] value;
    } check_entry_t;

    // Writebacks still land in the shadow file while the core is running or
    // draining its pipeline; afterwards the snapshot is frozen.
    function automatic logic capture_state(input state_t s);
        return (s == RUN) || (s == DRAIN);
    endfunction

endpackage : retire_chk_pkg

// File: rtl/retire_chk_shadow_rf.sv
// -----------------------------------------------------------------------------
// retire_chk_shadow_rf
//   Shadow copy of the architectural register file. Register 0 is hardwired
//   to zero; writes addressed to it are dropped.
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset (clears all)
//     we, waddr, wdata    single write port
//     dump_addr/_rdata    asynchronous read port used by the dump stream
//     chk_addr/_rdata     asynchronous read port used by the checker
// -----------------------------------------------------------------------------
module retire_chk_shadow_rf #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    localparam int IDXW = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [IDXW-1:0] waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [IDXW-1:0] dump_addr,
    output logic [XLEN-1:0] dump_rdata,
    input  logic [IDXW-1:0] chk_addr,
    output logic [XLEN-1:0] chk_rdata
);

    logic [XLEN-1:0] regs [NREGS];

    assign regs[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_reg
            logic [XLEN-1:0] reg_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    reg_q <= '0;
                end else if (we && (waddr == IDXW'(gi))) begin
                    reg_q <= wdata;
                end
            end

            assign regs[gi] = reg_q;
        end
    endgenerate

    assign dump_rdata = regs[dump_addr];
    assign chk_rdata  = regs[chk_addr];

endmodule : retire_chk_shadow_rf

// File: rtl/retire_checker.sv
// -----------------------------------------------------------------------------
// retire_checker
//   Simulation/FPGA test harness block. Shadows retiring register writebacks,
//   and after the core halts: waits DRAIN_CYCLES, streams the whole shadow
//   register file out over a valid/ready channel, then compares up to
//   NUM_CHECKS configured (register, expected value) entries and reports
//   done / pass / fail_count / first_fail_rd. DONE holds until reset.
//
//   Optional feature (compile-time macro RETIRE_CHK_WATCHDOG_EN):
//     a RUN-cycle watchdog; after TIMEOUT_CYCLES RUN cycles without halt the
//     block raises timeout and jumps straight to DONE with pass=0. A halt on
//     the expiry cycle wins. Without the macro timeout is tied low.
//
//   Ports
//     clk, rst_n                   clock, asynchronous active-low reset
//     wb_valid, wb_rd, wb_data     retiring register write
//     halt                         core halt indication
//     cfg_we, cfg_idx, cfg_rd,
//     cfg_val                      check-entry programming (RUN only)
//     dump_valid, dump_ready,
//     dump_idx, dump_data          register dump stream
//     done, pass, timeout,
//     fail_count, first_fail_rd    final verdict
// -----------------------------------------------------------------------------
module retire_checker
    import retire_chk_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int NREGS          = 32,
    parameter int DRAIN_CYCLES   = 10,
    parameter int NUM_CHECKS     = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int IDXW  = $clog2(NREGS),
    localparam int CIDXW = $clog2(NUM_CHECKS),
    localparam int FCW   = $clog2(NUM_CHECKS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_valid,
    input  logic [IDXW-1:0]  wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             halt,
    input  logic             cfg_we,
    input  logic [CIDXW-1:0] cfg_idx,
    input  logic [IDXW-1:0]  cfg_rd,
    input  logic [XLEN-1:0]  cfg_val,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [IDXW-1:0]  dump_idx,
    output logic [XLEN-1:0]  dump_data,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [FCW-1:0]   fail_count,
    output logic [IDXW-1:0]  first_fail_rd
);

    // The drain counter is loaded with DRAIN_CYCLES-1 and the FSM leaves
    // DRAIN on the cycle it reads zero, giving exactly DRAIN_CYCLES cycles.
    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

    state_t            state_q;
    logic [7:0]        drain_cnt_q;
    logic              dump_valid_q;
    logic [IDXW-1:0]   dump_idx_q;
    logic [CIDXW-1:0]  chk_idx_q;
    logic              done_q;
    logic              pass_q;
    logic [FCW-1:0]    fail_count_q;
    logic [IDXW-1:0]   first_fail_rd_q;

`ifdef RETIRE_CHK_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0]    wd_cnt_q;
    logic              timeout_q;
    assign timeout = timeout_q;
`else
    // Tied low. Written as a comparison on the (non-negative) limit so the
    // parameter stays referenced when the watchdog is compiled out.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    // ------------------------------------------------------------------
    // Shadow register file
    // ------------------------------------------------------------------
    logic            sh_we;
    logic [XLEN-1:0] dump_rdata;
    logic [IDXW-1:0] chk_addr;
    logic [XLEN-1:0] chk_rdata;

    assign sh_we = wb_valid && capture_state(state_q);

    retire_chk_shadow_rf #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_shadow_rf (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (sh_we),
        .waddr      (wb_rd),
        .wdata      (wb_data),
        .dump_addr  (dump_idx_q),
        .dump_rdata (dump_rdata),
        .chk_addr   (chk_addr),
        .chk_rdata  (chk_rdata)
    );

    // ------------------------------------------------------------------
    // Check-entry table, programmable only while RUN
    // ------------------------------------------------------------------
    check_entry_t entries [NUM_CHECKS];
    logic         cfg_accept;

    assign cfg_accept = cfg_we && (state_q == RUN);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHECKS; gi++) begin : g_entry
            check_entry_t entry_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_q <= '0;
                end else if (cfg_accept && (cfg_idx == CIDXW'(gi))) begin
                    entry_q <= '{enable: 1'b1,
                                 rd:     CHK_RD_W'(cfg_rd),
                                 value:  CHK_VAL_W'(cfg_val)};
                end
            end

            assign entries[gi] = entry_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Compare path for the entry currently selected in CHECK
    // ------------------------------------------------------------------
    check_entry_t         cur_entry;
    logic                 chk_rd_in_range;
    logic [CHK_VAL_W-1:0] chk_actual;
    logic                 chk_mismatch;
    logic                 chk_last;

    assign cur_entry       = entries[chk_idx_q];
    assign chk_addr        = cur_entry.rd[IDXW-1:0];
    // With a non power-of-two NREGS an index can name a register that does
    // not exist; such entries compare against zero, the same as x0.
    assign chk_rd_in_range = (cur_entry.rd < CHK_RD_W'(NREGS));
    assign chk_actual      = chk_rd_in_range ? CHK_VAL_W'(chk_rdata) : '0;
    assign chk_mismatch    = cur_entry.enable && (chk_actual != cur_entry.value);
    assign chk_last        = (chk_idx_q == CIDXW'(NUM_CHECKS - 1));

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= RUN;
            drain_cnt_q     <= '0;
            dump_valid_q    <= 1'b0;
            dump_idx_q      <= '0;
            chk_idx_q       <= '0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            fail_count_q    <= '0;
            first_fail_rd_q <= '0;
`ifdef RETIRE_CHK_WATCHDOG_EN
            wd_cnt_q        <= '0;
            timeout_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                RUN: begin
                    if (halt) begin
                        state_q     <= DRAIN;
                        drain_cnt_q <= DRAIN_LOAD;
                    end
`ifdef RETIRE_CHK_WATCHDOG_EN
                    else if (wd_cnt_q == WDW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        pass_q    <= 1'b0;
                        state_q   <= DONE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
`endif
                end

                DRAIN: begin
                    if (drain_cnt_q == 8'd0) begin
                        state_q      <= DUMP;
                        dump_valid_q <= 1'b1;
                        dump_idx_q   <= '0;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - 8'd1;
                    end
                end

                DUMP: begin
                    if (dump_ready) begin
                        if (dump_idx_q == IDXW'(NREGS - 1)) begin
                            state_q      <= CHECK;
                            dump_valid_q <= 1'b0;
                            dump_idx_q   <= '0;
                            chk_idx_q    <= '0;
                        end else begin
                            dump_idx_q <= dump_idx_q + 1'b1;
                        end
                    end
                end

                CHECK: begin
                    if (chk_mismatch) begin
                        fail_count_q <= fail_count_q + 1'b1;
                        if (fail_count_q == '0) begin
                            first_fail_rd_q <= chk_addr;
                        end
                    end
                    if (chk_last) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        // Include the final entry's result, which is only
                        // folded into fail_count_q on this same edge.
                        pass_q  <= (fail_count_q == '0) && !chk_mismatch && !timeout;
                    end else begin
                        chk_idx_q <= chk_idx_q + 1'b1;
                    end
                end

                DONE: begin
                    state_q <= DONE;
                end

                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    // Shadow contents are frozen during DUMP, so a combinational read from
    // the registered index is stable for as long as the beat is stalled.
    assign dump_valid    = dump_valid_q;
    assign dump_idx      = dump_idx_q;
    assign dump_data     = dump_valid_q ? dump_rdata : '0;
    assign done          = done_q;
    assign pass          = pass_q;
    assign fail_count    = fail_count_q;
    assign first_fail_rd = first_fail_rd_q;

endmodule : retire_checker

// File: tb/tb_retire_checker.sv
// -----------------------------------------------------------------------------
// tb_retire_checker
//   Self-checking bench for retire_checker: directed scenarios plus random
//   rounds, all compared against a plain array model of the register file
//   and check table. Watchdog scenarios run when RETIRE_CHK_WATCHDOG_EN is
//   defined.
// -----------------------------------------------------------------------------
module tb_retire_checker;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int DRAIN = 10;
    localparam int NCHK  = 4;
    localparam int IDXW  = $clog2(NREGS);
    localparam int CIDXW = $clog2(NCHK);
    localparam int FCW   = $clog2(NCHK + 1);
`ifdef RETIRE_CHK_WATCHDOG_EN
    localparam int TMO   = 300;
`else
    localparam int TMO   = 100000;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wb_valid = 1'b0;
    logic [IDXW-1:0]  wb_rd = '0;
    logic [XLEN-1:0]  wb_data = '0;
    logic             halt = 1'b0;
    logic             cfg_we = 1'b0;
    logic [CIDXW-1:0] cfg_idx = '0;
    logic [IDXW-1:0]  cfg_rd = '0;
    logic [XLEN-1:0]  cfg_val = '0;
    logic             dump_ready = 1'b0;
    logic             dump_valid;
    logic [IDXW-1:0]  dump_idx;
    logic [XLEN-1:0]  dump_data;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [FCW-1:0]   fail_count;
    logic [IDXW-1:0]  first_fail_rd;

    retire_checker #(
        .XLEN           (XLEN),
        .NREGS          (NREGS),
        .DRAIN_CYCLES   (DRAIN),
        .NUM_CHECKS     (NCHK),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .halt          (halt),
        .cfg_we        (cfg_we),
        .cfg_idx       (cfg_idx),
        .cfg_rd        (cfg_rd),
        .cfg_val       (cfg_val),
        .dump_valid    (dump_valid),
        .dump_ready    (dump_ready),
        .dump_idx      (dump_idx),
        .dump_data     (dump_data),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .fail_count    (fail_count),
        .first_fail_rd (first_fail_rd)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard counters and the single comparison task
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [XLEN-1:0] obs,
                            input logic [XLEN-1:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: architectural view only
    // ------------------------------------------------------------------
    logic [XLEN-1:0] m_rf  [NREGS];
    bit              m_en  [NCHK];
    logic [IDXW-1:0] m_rd  [NCHK];
    logic [XLEN-1:0] m_val [NCHK];

    function automatic void model_reset();
        for (int i = 0; i < NREGS; i++) m_rf[i] = '0;
        for (int i = 0; i < NCHK; i++) begin
            m_en[i]  = 1'b0;
            m_rd[i]  = '0;
            m_val[i] = '0;
        end
    endfunction

    function automatic logic [XLEN-1:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // ------------------------------------------------------------------
    // Drive helpers; every step ends on a falling edge
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wb_valid   = 1'b0;
        cfg_we     = 1'b0;
        halt       = 1'b0;
        dump_ready = 1'b0;
    endtask

    task automatic junk_cfg();
        cfg_we  = 1'($urandom_range(1));
        cfg_idx = CIDXW'($urandom_range(NCHK - 1));
        cfg_rd  = IDXW'($urandom_range(NREGS - 1));
        cfg_val = rand64();
    endtask

    task automatic junk_wb();
        wb_valid = 1'($urandom_range(1));
        wb_rd    = IDXW'($urandom_range(NREGS - 1));
        wb_data  = rand64();
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_dump_valid"}, XLEN'(dump_valid), '0);
        check_eq({pfx, "_dump_idx"}, XLEN'(dump_idx), '0);
        check_eq({pfx, "_dump_data"}, dump_data, '0);
        check_eq({pfx, "_done"}, XLEN'(done), '0);
        check_eq({pfx, "_pass"}, XLEN'(pass), '0);
        check_eq({pfx, "_timeout"}, XLEN'(timeout), '0);
        check_eq({pfx, "_fail_count"}, XLEN'(fail_count), '0);
        check_eq({pfx, "_first_fail_rd"}, XLEN'(first_fail_rd), '0);
    endtask

    task automatic do_reset(input bit chk);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #2;
        if (chk) check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One RUN-phase cycle with optional writeback and cfg write.
    task automatic run_cycle(input bit wv, input logic [IDXW-1:0] wrd,
                             input logic [XLEN-1:0] wdat, input bit cv,
                             input logic [CIDXW-1:0] cidx,
                             input logic [IDXW-1:0] crd,
                             input logic [XLEN-1:0] cval);
        wb_valid = wv;  wb_rd  = wrd;  wb_data = wdat;
        cfg_we   = cv;  cfg_idx = cidx; cfg_rd = crd; cfg_val = cval;
        if (wv && wrd != '0) m_rf[wrd] = wdat;
        if (cv) begin
            m_en[cidx]  = 1'b1;
            m_rd[cidx]  = crd;
            m_val[cidx] = cval;
        end
        step();
        idle_inputs();
    endtask

    // ------------------------------------------------------------------
    // Halt, drain, dump and verdict. ready_mode: 0 always, 1 toggle,
    // 2 random. drain_wb_cyc 0 = no drain writeback. abort_beat >= 0
    // asserts reset while that beat is being presented.
    // ------------------------------------------------------------------
    task automatic halt_and_finish(input string name, input int ready_mode,
                                   input int drain_wb_cyc,
                                   input logic [IDXW-1:0] drain_rd,
                                   input logic [XLEN-1:0] drain_data,
                                   input int abort_beat);
        int exp_idx;
        int cyc;
        int exp_fail;
        logic [IDXW-1:0] exp_first;
        logic [XLEN-1:0] actual;
        bit rdy;

        halt = 1'b1;
        step();
        halt = 1'b0;

        for (int c = 1; c <= DRAIN; c++) begin
            junk_cfg();
            halt = 1'($urandom_range(1));
            if (c == drain_wb_cyc) begin
                wb_valid = 1'b1;
                wb_rd    = drain_rd;
                wb_data  = drain_data;
                if (drain_rd != '0) m_rf[drain_rd] = drain_data;
            end
            step();
            idle_inputs();
            if (c == DRAIN - 1) check_eq({name, "_drain_valid_low"}, XLEN'(dump_valid), '0);
            if (c == DRAIN) check_eq({name, "_dump_start"}, XLEN'(dump_valid), XLEN'(1));
        end

        exp_idx = 0;
        cyc     = 0;
        while (exp_idx < NREGS && cyc < 2000) begin
            check_eq($sformatf("%s_beat%0d_valid", name, exp_idx), XLEN'(dump_valid), XLEN'(1));
            check_eq($sformatf("%s_beat%0d_idx", name, exp_idx), XLEN'(dump_idx), XLEN'(exp_idx));
            check_eq($sformatf("%s_beat%0d_data", name, exp_idx), dump_data, m_rf[exp_idx]);
            if (exp_idx == abort_beat) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_reset_outputs({name, "_abort"});
                @(negedge clk);
                rst_n = 1'b1;
                model_reset();
                $display("scenario %s: aborted by reset at beat %0d", name, exp_idx);
                return;
            end
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(1));
            endcase
            dump_ready = rdy;
            junk_wb();
            junk_cfg();
            step();
            idle_inputs();
            if (rdy) exp_idx++;
            cyc++;
        end
        check_eq({name, "_dump_beats"}, XLEN'(exp_idx), XLEN'(NREGS));
        check_eq({name, "_valid_after_last"}, XLEN'(dump_valid), '0);
        check_eq({name, "_done_early"}, XLEN'(done), '0);

        // Expected verdict from the model's register and check tables.
        exp_fail  = 0;
        exp_first = '0;
        for (int i = 0; i < NCHK; i++) begin
            if (m_en[i]) begin
                actual = (m_rd[i] == '0) ? '0 : m_rf[m_rd[i]];
                if (actual != m_val[i]) begin
                    if (exp_fail == 0) exp_first = m_rd[i];
                    exp_fail++;
                end
            end
        end

        for (int k = 1; k < NCHK; k++) begin
            junk_wb();
            step();
            idle_inputs();
        end
        check_eq({name, "_done_before_last"}, XLEN'(done), '0);
        junk_wb();
        step();
        idle_inputs();
        check_eq({name, "_done"}, XLEN'(done), XLEN'(1));
        check_eq({name, "_pass"}, XLEN'(pass), XLEN'(exp_fail == 0));
        check_eq({name, "_fail_count"}, XLEN'(fail_count), XLEN'(exp_fail));
        check_eq({name, "_first_fail_rd"}, XLEN'(first_fail_rd), XLEN'(exp_first));
        check_eq({name, "_timeout"}, XLEN'(timeout), '0);

        // DONE must hold whatever the core does afterwards.
        for (int k = 0; k < 3; k++) begin
            junk_wb();
            junk_cfg();
            halt = 1'b1;
            step();
            idle_inputs();
        end
        check_eq({name, "_done_hold"}, XLEN'(done), XLEN'(1));
        check_eq({name, "_fail_hold"}, XLEN'(fail_count), XLEN'(exp_fail));
        check_eq({name, "_no_redump"}, XLEN'(dump_valid), '0);
        $display("scenario %s: expected fail_count=%0d first_fail_rd=%0d, observed fail_count=%0d pass=%0d",
                 name, exp_fail, exp_first, fail_count, pass);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        model_reset();

        // REQ-030 style: two matching checks, plus overwrite and rd=0 entry.
        do_reset(1'b1);
        run_cycle(1, IDXW'(15), XLEN'(64'h28), 1, 2'd0, IDXW'(15), XLEN'(64'hdead));
        run_cycle(1, IDXW'(13), XLEN'(64'h1010), 0, '0, '0, '0);
        run_cycle(0, '0, '0, 1, 2'd0, IDXW'(15), XLEN'(64'h28));
        run_cycle(0, '0, '0, 1, 2'd1, IDXW'(13), XLEN'(64'h1010));
        run_cycle(0, '0, '0, 1, 2'd2, IDXW'(0), XLEN'(64'h0));
        halt_and_finish("basic_pass", 0, 0, '0, '0, -1);

        // REQ-031 style: single mismatch on x13.
        do_reset(1'b0);
        run_cycle(0, '0, '0, 1, 2'd0, IDXW'(13), XLEN'(64'h1010));
        run_cycle(1, IDXW'(13), XLEN'(64'h1008), 0, '0, '0, '0);
        halt_and_finish("single_fail", 0, 0, '0, '0, -1);

        // Drain-window writeback, x0 write, toggling ready, rd=0 mismatch.
        do_reset(1'b0);
        run_cycle(1, IDXW'(0), XLEN'(64'hFF), 1, 2'd3, IDXW'(0), XLEN'(64'h5));
        run_cycle(1, IDXW'(5), XLEN'(64'h3), 1, 2'd1, IDXW'(5), XLEN'(64'h7));
        halt_and_finish("drain_wb_toggle", 1, 3, IDXW'(5), XLEN'(64'h7), -1);

        // Reset in the middle of the dump, then a clean run afterwards.
        do_reset(1'b0);
        run_cycle(1, IDXW'(3), XLEN'(64'h33), 1, 2'd0, IDXW'(3), XLEN'(64'h33));
        halt_and_finish("abort_dump", 0, 0, '0, '0, 10);
        step();
        check_eq("post_abort_run_valid", XLEN'(dump_valid), '0);
        check_eq("post_abort_run_done", XLEN'(done), '0);
        run_cycle(1, IDXW'(7), XLEN'(64'h55), 1, 2'd1, IDXW'(7), XLEN'(64'h55));
        run_cycle(0, '0, '0, 1, 2'd2, IDXW'(3), XLEN'(64'h0));
        halt_and_finish("after_abort", 0, 0, '0, '0, -1);

        // Random rounds.
        for (int r = 0; r < 6; r++) begin
            int n;
            do_reset(1'b0);
            n = 20 + $urandom_range(20);
            for (int k = 0; k < n; k++) begin
                bit               wv, cv;
                logic [IDXW-1:0]  wrd, crd;
                logic [CIDXW-1:0] cidx;
                logic [XLEN-1:0]  cval;
                wv   = ($urandom_range(2) != 0);
                wrd  = ($urandom_range(4) == 0) ? '0 : IDXW'($urandom_range(7));
                if ($urandom_range(1) == 1) wrd = IDXW'($urandom_range(NREGS - 1));
                cv   = ($urandom_range(3) == 0);
                cidx = CIDXW'($urandom_range(NCHK - 1));
                crd  = ($urandom_range(5) == 0) ? '0 : IDXW'($urandom_range(7));
                cval = ($urandom_range(1) == 1) ? m_rf[crd] : rand64();
                run_cycle(wv, wrd, rand64(), cv, cidx, crd, cval);
            end
            halt_and_finish($sformatf("random%0d", r), 2, $urandom_range(DRAIN),
                            IDXW'($urandom_range(7)), rand64(), -1);
        end

`ifdef RETIRE_CHK_WATCHDOG_EN
        // Watchdog expiry without halt.
        begin
            int saw_valid;
            saw_valid = 0;
            do_reset(1'b0);
            for (int k = 1; k < TMO; k++) begin
                step();
                if (dump_valid) saw_valid++;
            end
            check_eq("wd_done_before_expiry", XLEN'(done), '0);
            check_eq("wd_timeout_before_expiry", XLEN'(timeout), '0);
            step();
            check_eq("wd_done", XLEN'(done), XLEN'(1));
            check_eq("wd_timeout", XLEN'(timeout), XLEN'(1));
            check_eq("wd_pass", XLEN'(pass), '0);
            check_eq("wd_fail_count", XLEN'(fail_count), '0);
            for (int k = 0; k < 20; k++) begin
                halt = 1'b1;
                step();
                if (dump_valid) saw_valid++;
            end
            halt = 1'b0;
            check_eq("wd_no_dump", XLEN'(saw_valid), '0);
            check_eq("wd_done_hold", XLEN'(done), XLEN'(1));
            $display("scenario watchdog: timeout=%0d done=%0d pass=%0d", timeout, done, pass);
        end

        // Halt on the expiry cycle wins over the watchdog.
        do_reset(1'b0);
        for (int k = 1; k < TMO; k++) step();
        halt_and_finish("wd_halt_race", 0, 0, '0, '0, -1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no completion expected completion within bound");
        $fatal(1, "bench time limit expired");
    end

endmodule : tb_retire_checker

// File: doc/retire_checker.md
RETIRE_CHECKER -- requirements
Module: retire_checker

Interface
REQ-001 The module SHALL have parameter XLEN, default 64, datapath width of writeback and check values.
REQ-002 The module SHALL have parameter NREGS, default 32, architectural register count; register index width is $clog2(NREGS).
REQ-003 The module SHALL have parameter DRAIN_CYCLES, default 10, cycles waited after halt before dump (legal range 1..255).
REQ-004 The module SHALL have parameter NUM_CHECKS, default 4, number of expected-value check entries.
REQ-005 The module SHALL have parameter TIMEOUT_CYCLES, default 100000, watchdog limit in RUN cycles.
REQ-006 The module SHALL have ports: clk  in  1  sole clock; rst_n  in  1  asynchronous active-low reset.
REQ-007 The module SHALL have ports: wb_valid  in  1  register write retiring; wb_rd  in  IDXW  destination index; wb_data  in  XLEN  written value.
REQ-008 The module SHALL have port: halt  in  1  core halt indication.
REQ-009 The module SHALL have ports: cfg_we  in  1  check-entry write; cfg_idx  in  $clog2(NUM_CHECKS)  entry; cfg_rd  in  IDXW  register to check; cfg_val  in  XLEN  expected value.
REQ-010 The module SHALL have ports: dump_valid  out  1; dump_ready  in  1; dump_idx  out  IDXW; dump_data  out  XLEN  (register dump stream, valid/ready).
REQ-011 The module SHALL have ports: done  out  1; pass  out  1; timeout  out  1; fail_count  out  $clog2(NUM_CHECKS+1); first_fail_rd  out  IDXW.

Function
REQ-012 FSM states SHALL be RUN, DRAIN, DUMP, CHECK, DONE; RUN after reset.
REQ-013 In RUN and DRAIN, wb_valid with wb_rd!=0 SHALL update shadow[wb_rd] with wb_data on the same edge; wb_rd==0 writes discarded, shadow[0] reads 0.
REQ-014 In DUMP, CHECK and DONE, writebacks SHALL be ignored.
REQ-015 halt sampled high in RUN SHALL move to DRAIN and load drain counter; halt deassertion during DRAIN SHALL be ignored.
REQ-016 DRAIN SHALL last exactly DRAIN_CYCLES cycles, then enter DUMP.
REQ-017 DUMP SHALL present dump_valid=1, dump_idx from 0, dump_data=shadow[dump_idx]; index advances only on dump_valid&&dump_ready; dump_idx/dump_data stable while stalled.
REQ-018 Beat with dump_idx==NREGS-1 accepted SHALL move to CHECK; dump_valid low the following cycle.
REQ-019 CHECK SHALL evaluate one entry per cycle, index 0..NUM_CHECKS-1 (NUM_CHECKS cycles); enabled entry with shadow[cfg_rd]!=cfg_val increments fail_count; first mismatch latches first_fail_rd.
REQ-020 After last entry, FSM SHALL enter DONE: done=1, pass=(fail_count==0)&&!timeout; DONE holds until reset.
REQ-021 cfg_we SHALL be accepted only in RUN, setting entry enable; writes in other states ignored; cfg_we and wb_valid in the same cycle both take effect.
REQ-022 Rewriting an entry SHALL overwrite rd/value; last write wins.
REQ-023 A check entry's rd of 0 SHALL compare against 0.

Reset
REQ-024 rst_n low SHALL asynchronously force: state RUN, shadow all 0, all check enables 0, counters 0, dump_valid 0, done 0, pass 0, timeout 0, fail_count 0, first_fail_rd 0, dump_idx 0, dump_data 0.
REQ-025 Reset mid-DRAIN/DUMP/CHECK SHALL abort without completing; no partial done.

Configuration
REQ-026 With RETIRE_CHK_WATCHDOG_EN defined, a RUN-cycle counter SHALL, on reaching TIMEOUT_CYCLES without halt, set timeout=1, skip DRAIN/DUMP/CHECK and enter DONE with pass=0; halt on the same cycle as expiry takes priority (DRAIN).
REQ-027 Without RETIRE_CHK_WATCHDOG_EN, the counter SHALL not exist and timeout SHALL be constant 0.

Structure
REQ-028 Package retire_chk_pkg SHALL hold the state enum and check-entry struct (enable, rd, value); XLEN/NREGS-dependent widths remain module parameters.
REQ-029 Shadow register storage SHALL be sub-module retire_chk_shadow_rf (one write port, two async read ports: dump, check).

Verification
REQ-030 Write x15=0x28, x13=0x1010; checks {x15:0x28, x13:0x1010}; halt -> after 10 drain cycles 32 dump beats, done=1, pass=1, fail_count=0.
REQ-031 Checks {x13:0x1010}, x13 written 0x1008 -> pass=0, fail_count=1, first_fail_rd=13.
REQ-032 Writeback x5=0x7 during DRAIN cycle 3 -> dump beat 5 shows 0x7; writeback during DUMP not reflected.
REQ-033 dump_ready toggled 1-0-1 every cycle -> 32 beats in order 0..31, data stable when stalled; wb to x0=0xFF -> beat 0 is 0.
REQ-034 Reset asserted mid-DUMP at beat 10 -> all outputs 0 immediately, FSM restarts in RUN.
REQ-035 RETIRE_CHK_WATCHDOG_EN, TIMEOUT_CYCLES=50, no halt -> cycle 50 done=1, timeout=1, pass=0, no dump_valid.
